// File: rtl/div_request_sequencer.sv
// Request FIFO + sequencer that feeds a multi-cycle divider and holds its result for a ready/valid sink.
// Optional DIV_BY_ZERO_CHECK_EN: zero divisors bypass the divider and return all-ones / dividend.
module div_request_sequencer #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Div_Reset,
    output logic             Div_Run,
    input  logic             Div_Ready,
    output logic [WIDTH-1:0] Div_Dividend,
    output logic [WIDTH-1:0] Div_Divisor,
    input  logic [WIDTH-1:0] Div_Quotient,
    input  logic [WIDTH-1:0] Div_Remainder,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Div_zero,
    output logic             Busy
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] dividend;
        logic [WIDTH-1:0] divisor;
    } req_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

    state_t           state, state_next;
    req_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    req_t             head, operand;
    logic [WIDTH-1:0] quo_q, rem_q;
    logic             out_valid_q;
    logic             fifo_empty, push, pop, capture, release_res, head_zero, zero_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head       = fifo_mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign In_ready   = !Reset && (count < CNT_W'(FIFO_DEPTH));
    assign push       = In_valid && In_ready;
    assign zero_pop   = pop && head_zero;

    // Request FIFO
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {Dividend, Divisor};
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) begin
                pop        = 1'b1;
                state_next = head_zero ? HOLD : LOAD;
            end
            LOAD: state_next = RUN;
            RUN: if (Div_Ready) begin
                capture    = 1'b1;
                state_next = HOLD;
            end
            HOLD: if (Out_ready) begin
                release_res = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = head_zero ? HOLD : LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A zero-divisor pop in HOLD overrides the release so the new result appears back to back.
    always_ff @(posedge clk) begin
        if (Reset) begin
            operand     <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (pop) operand <= head;
            if (release_res) out_valid_q <= 1'b0;
            if (capture) begin
                quo_q       <= Div_Quotient;
                rem_q       <= Div_Remainder;
                out_valid_q <= 1'b1;
            end
            if (zero_pop) begin
                quo_q       <= '1;
                rem_q       <= head.dividend;
                out_valid_q <= 1'b1;
            end
        end
    end

`ifdef DIV_BY_ZERO_CHECK_EN
    logic div_zero_q;

    always_ff @(posedge clk) begin
        if (Reset)            div_zero_q <= 1'b0;
        else if (zero_pop)    div_zero_q <= 1'b1;
        else if (release_res) div_zero_q <= 1'b0;
    end

    assign head_zero = (head.divisor == '0);
    assign Div_zero  = div_zero_q && !Reset;
`else
    assign head_zero = 1'b0;
    assign Div_zero  = 1'b0;
`endif

    assign Div_Dividend = operand.dividend;
    assign Div_Divisor  = operand.divisor;
    assign Div_Reset    = Reset || (state == LOAD);
    assign Div_Run      = !Reset && (state == RUN);
    assign Busy         = !Reset && (state != IDLE);
    assign Out_valid    = out_valid_q && !Reset;
    assign Quotient     = quo_q;
    assign Remainder    = rem_q;
endmodule

// File: tb/tb_div_request_sequencer.sv
// Directed bench for div_request_sequencer with a 4-cycle behavioural divider model.
module tb_div_request_sequencer;
    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        In_valid = 1'b0;
    logic        In_ready;
    logic [31:0] Dividend = '0, Divisor = '0;
    logic        Div_Reset, Div_Run;
    logic        Div_Ready;
    logic [31:0] Div_Dividend, Div_Divisor;
    logic [31:0] Div_Quotient, Div_Remainder;
    logic        Out_valid;
    logic        Out_ready = 1'b0;
    logic [31:0] Quotient, Remainder;
    logic        Div_zero, Busy;

    int n_cmp = 0;
    int n_err = 0;

    div_request_sequencer #(.WIDTH(32), .FIFO_DEPTH(2)) dut (
        .clk(clk), .Reset(Reset),
        .In_valid(In_valid), .In_ready(In_ready), .Dividend(Dividend), .Divisor(Divisor),
        .Div_Reset(Div_Reset), .Div_Run(Div_Run), .Div_Ready(Div_Ready),
        .Div_Dividend(Div_Dividend), .Div_Divisor(Div_Divisor),
        .Div_Quotient(Div_Quotient), .Div_Remainder(Div_Remainder),
        .Out_valid(Out_valid), .Out_ready(Out_ready), .Quotient(Quotient), .Remainder(Remainder),
        .Div_zero(Div_zero), .Busy(Busy)
    );

    always #5 clk = ~clk;

    // Divider model: ready after 4 run cycles, holds result until the next Div_Reset.
    logic [31:0] m_q = '0, m_r = '0;
    logic        m_rdy = 1'b0;
    int          m_cnt = 0;
    assign Div_Ready     = m_rdy;
    assign Div_Quotient  = m_q;
    assign Div_Remainder = m_r;

    always @(posedge clk) begin
        if (Div_Reset) begin
            m_rdy <= 1'b0;
            m_cnt <= 0;
        end else if (Div_Run && !m_rdy) begin
            if (m_cnt == 3) begin
                m_rdy <= 1'b1;
                if (Div_Divisor == 0) begin
                    m_q <= 32'h0BAD_0BAD;
                    m_r <= 32'h0000_0777;
                end else begin
                    m_q <= Div_Dividend / Div_Divisor;
                    m_r <= Div_Dividend % Div_Divisor;
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Accepted results and activity counters
    logic [31:0] res_q[$];
    logic [31:0] res_r[$];
    logic        res_z[$];
    int          run_cycles = 0;
    int          rst_pulses = 0;

    always @(posedge clk) begin
        if (!Reset && Out_valid && Out_ready) begin
            res_q.push_back(Quotient);
            res_r.push_back(Remainder);
            res_z.push_back(Div_zero);
        end
        if (Div_Run) run_cycles++;
        if (Div_Reset && !Reset) rst_pulses++;
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int t = 0;
        In_valid = 1'b1;
        Dividend = a;
        Divisor  = b;
        while (!In_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!In_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: In_ready=%0b required 1 for %0d/%0d", In_ready, a, b);
        end
        @(negedge clk);
        In_valid = 1'b0;
    endtask

    task automatic wait_out();
        int t = 0;
        while (!Out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!Out_valid) begin
            n_cmp++; n_err++;
            $display("FAIL out_timeout: Out_valid=%0b required 1", Out_valid);
        end
    endtask

    task automatic wait_results(input int n);
        int t = 0;
        while (res_q.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (res_q.size() !== n) begin
            n_err++;
            $display("FAIL result_count: got %0d required %0d", res_q.size(), n);
        end
    endtask

    task automatic clear_results();
        res_q.delete(); res_r.delete(); res_z.delete();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({In_ready, Busy, Out_valid, Div_Run, Div_zero, Div_Reset} !== 6'b000001) begin
            n_err++;
            $display("FAIL reset_ctrl: {rdy,busy,ov,run,z,drst}=%b required 000001",
                     {In_ready, Busy, Out_valid, Div_Run, Div_zero, Div_Reset});
        end
        n_cmp++;
        if ({Quotient, Remainder, Div_Dividend, Div_Divisor} !== 128'h0) begin
            n_err++;
            $display("FAIL reset_regs: q=%h r=%h dd=%h dv=%h required 0", Quotient, Remainder,
                     Div_Dividend, Div_Divisor);
        end
        Reset = 1'b0;
        #1;
        n_cmp++;
        if (In_ready !== 1'b1 || Div_Reset !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: In_ready=%b Div_Reset=%b required 1 0", In_ready, Div_Reset);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        clear_results();
        rst_pulses = 0;
        Out_ready  = 1'b0;
        send(100, 7);
        n_cmp++;
        if (Busy !== 1'b0 || Div_Reset !== 1'b0) begin
            n_err++;
            $display("FAIL basic_idle: Busy=%b Div_Reset=%b required 0 0", Busy, Div_Reset);
        end
        @(negedge clk);
        n_cmp++;
        if (Div_Reset !== 1'b1 || Busy !== 1'b1 || Div_Dividend !== 100 || Div_Divisor !== 7) begin
            n_err++;
            $display("FAIL basic_load: Div_Reset=%b Busy=%b dd=%0d dv=%0d required 1 1 100 7",
                     Div_Reset, Busy, Div_Dividend, Div_Divisor);
        end
        @(negedge clk);
        n_cmp++;
        if (Div_Run !== 1'b1 || Div_Reset !== 1'b0) begin
            n_err++;
            $display("FAIL basic_run: Div_Run=%b Div_Reset=%b required 1 0", Div_Run, Div_Reset);
        end
        wait_out();
        n_cmp++;
        if (Quotient !== 14 || Remainder !== 2 || Div_zero !== 1'b0 || rst_pulses !== 1) begin
            n_err++;
            $display("FAIL basic_result: q=%0d r=%0d z=%b pulses=%0d required 14 2 0 1",
                     Quotient, Remainder, Div_zero, rst_pulses);
        end
        Out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (Out_valid !== 1'b0 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_release: Out_valid=%b Busy=%b required 0 0", Out_valid, Busy);
        end
        Out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[4];
        logic [31:0] exp_r[4];
        exp_q = '{6, 7, 6, 7};
        exp_r = '{2, 2, 4, 1};
        clear_results();
        Out_ready = 1'b1;
        send(20, 3);
        repeat (3) @(negedge clk);
        In_valid = 1'b1; Dividend = 30; Divisor = 4;
        n_cmp++;
        if (In_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_ready1: In_ready=%b required 1", In_ready);
        end
        @(negedge clk);
        Dividend = 40; Divisor = 6;
        n_cmp++;
        if (In_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_ready2: In_ready=%b required 1", In_ready);
        end
        @(negedge clk);
        In_valid = 1'b0;
        n_cmp++;
        if (In_ready !== 1'b0 || Div_Run !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_full: In_ready=%b Div_Run=%b required 0 1", In_ready, Div_Run);
        end
        send(50, 7);
        wait_results(4);
        for (int i = 0; i < 4 && i < res_q.size(); i++) begin
            n_cmp++;
            if (res_q[i] !== exp_q[i] || res_r[i] !== exp_r[i]) begin
                n_err++;
                $display("FAIL b2b_order[%0d]: q=%0d r=%0d required %0d %0d", i, res_q[i], res_r[i],
                         exp_q[i], exp_r[i]);
            end
        end
        Out_ready = 1'b0;
    endtask

    task automatic test_hold();
        clear_results();
        Out_ready = 1'b0;
        send(77, 5);
        wait_out();
        send(64, 8);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (Out_valid !== 1'b1 || Quotient !== 15 || Remainder !== 2 || Div_Run !== 1'b0 ||
                Div_Reset !== 1'b0) begin
                n_err++;
                $display("FAIL hold_stable[%0d]: ov=%b q=%0d r=%0d run=%b drst=%b required 1 15 2 0 0",
                         i, Out_valid, Quotient, Remainder, Div_Run, Div_Reset);
            end
            @(negedge clk);
        end
        Out_ready = 1'b1;
        @(negedge clk);
        Out_ready = 1'b0;
        n_cmp++;
        if (Div_Reset !== 1'b1 || Out_valid !== 1'b0 || Div_Dividend !== 64 || In_ready !== 1'b1) begin
            n_err++;
            $display("FAIL hold_pop: drst=%b ov=%b dd=%0d rdy=%b required 1 0 64 1",
                     Div_Reset, Out_valid, Div_Dividend, In_ready);
        end
        wait_out();
        n_cmp++;
        if (Quotient !== 8 || Remainder !== 0) begin
            n_err++; $display("FAIL hold_second: q=%0d r=%0d required 8 0", Quotient, Remainder);
        end
        Out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        clear_results();
        Out_ready = 1'b1;
        send(1000, 10);
        send(5, 5);
        @(negedge clk);
        n_cmp++;
        if (Div_Run !== 1'b1) begin
            n_err++; $display("FAIL rst_run_setup: Div_Run=%b required 1", Div_Run);
        end
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        #1;
        n_cmp++;
        if (Busy !== 1'b0 || Out_valid !== 1'b0 || Div_Run !== 1'b0 || In_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_after: busy=%b ov=%b run=%b rdy=%b required 0 0 0 1",
                     Busy, Out_valid, Div_Run, In_ready);
        end
        repeat (15) @(negedge clk);
        n_cmp++;
        if (res_q.size() !== 0 || Busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_flushed: results=%0d busy=%b required 0 0", res_q.size(), Busy);
        end
        send(9, 3);
        wait_results(1);
        n_cmp++;
        if (res_q.size() > 0 && (res_q[0] !== 3 || res_r[0] !== 0)) begin
            n_err++; $display("FAIL rst_followup: q=%0d r=%0d required 3 0", res_q[0], res_r[0]);
        end
        Out_ready = 1'b0;
    endtask

    task automatic test_div_zero();
        clear_results();
        Out_ready  = 1'b0;
        run_cycles = 0;
        send(55, 0);
        wait_out();
`ifdef DIV_BY_ZERO_CHECK_EN
        n_cmp++;
        if (Quotient !== 32'hFFFF_FFFF || Remainder !== 55 || Div_zero !== 1'b1 || run_cycles !== 0) begin
            n_err++;
            $display("FAIL dz_bypass: q=%h r=%0d z=%b runs=%0d required ffffffff 55 1 0",
                     Quotient, Remainder, Div_zero, run_cycles);
        end
`else
        n_cmp++;
        if (Quotient !== 32'h0BAD_0BAD || Remainder !== 32'h777 || Div_zero !== 1'b0 || run_cycles == 0) begin
            n_err++;
            $display("FAIL dz_passthru: q=%h r=%h z=%b runs=%0d required 0bad0bad 777 0 nonzero",
                     Quotient, Remainder, Div_zero, run_cycles);
        end
`endif
        Out_ready = 1'b1;
        @(negedge clk);
        Out_ready = 1'b0;
        n_cmp++;
        if (Out_valid !== 1'b0 || Div_zero !== 1'b0) begin
            n_err++;
            $display("FAIL dz_clear: ov=%b z=%b required 0 0", Out_valid, Div_zero);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold();
        test_reset_mid_run();
        test_div_zero();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
